stage_i_bf2i: RTL and testbench

- First (odd) stage of a radix-2² single-path delay-feedback (R2²SDF) pipeline FFT.
- Contains the BF2I trivial butterfly (add/subtract only, no twiddle), a feedback delay line of shift_stages words per real/imag path, and a registered output.
- Its output feeds directly into the prvs_r/prvs_i inputs of the following BF2II stage, which applies the twiddle multiply.
- Also reports when its delay line is primed, so the system controller knows when output data is meaningful.

---
 rtl/stage_i_bf2i.sv | 77 +++++++
 tb/tb_stage_i_bf2i.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stage_i_bf2i.sv
// First (BF2I) stage of a radix-2^2 SDF FFT: trivial add/subtract butterfly,
// feedback delay line of shift_stages words per path, registered output and prime flag.
module stage_i_bf2i #(
  parameter int data_width   = 14,
  parameter int add_g        = 1,
  parameter int shift_stages = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                s,
  input  logic signed [data_width-add_g-1:0]  prvs_r,
  input  logic signed [data_width-add_g-1:0]  prvs_i,
  output logic signed [data_width-1:0]        tonext_r,
  output logic signed [data_width-1:0]        tonext_i,
  output logic                                primed
);

  localparam int CNT_W = $clog2(shift_stages + 1);

  logic signed [data_width-1:0] x_r, x_i;
  logic signed [data_width-1:0] d_r, d_i;
  logic signed [data_width-1:0] toreg_r, toreg_i;
  logic signed [data_width-1:0] tonext_r_d, tonext_i_d;
  logic signed [data_width-1:0] tonext_r_q, tonext_i_q;
  logic signed [data_width-1:0] dly_r_q [shift_stages];
  logic signed [data_width-1:0] dly_i_q [shift_stages];
  logic        [CNT_W-1:0]      cnt_q, cnt_d;

  // Size cast of a signed operand sign-extends by add_g bits.
  assign x_r = data_width'(prvs_r);
  assign x_i = data_width'(prvs_i);
  assign d_r = dly_r_q[shift_stages-1];
  assign d_i = dly_i_q[shift_stages-1];

  always_comb begin
    toreg_r    = x_r;
    toreg_i    = x_i;
    tonext_r_d = d_r;
    tonext_i_d = d_i;
    if (s) begin
      tonext_r_d = d_r + x_r;
      tonext_i_d = d_i + x_i;
      toreg_r    = d_r - x_r;
      toreg_i    = d_i - x_i;
    end
  end

  assign cnt_d = (cnt_q == CNT_W'(shift_stages)) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < shift_stages; i++) begin
        dly_r_q[i] <= '0;
        dly_i_q[i] <= '0;
      end
      tonext_r_q <= '0;
      tonext_i_q <= '0;
      cnt_q      <= '0;
    end else if (enable) begin
      dly_r_q[0] <= toreg_r;
      dly_i_q[0] <= toreg_i;
      for (int i = 1; i < shift_stages; i++) begin
        dly_r_q[i] <= dly_r_q[i-1];
        dly_i_q[i] <= dly_i_q[i-1];
      end
      tonext_r_q <= tonext_r_d;
      tonext_i_q <= tonext_i_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tonext_r = tonext_r_q;
  assign tonext_i = tonext_i_q;
  assign primed   = (cnt_q == CNT_W'(shift_stages));

endmodule

// File: tb/tb_stage_i_bf2i.sv
// Directed bench for stage_i_bf2i: a 14-bit/add_g=1/depth-4 instance and an
// 8-bit/add_g=0/depth-1 instance for the wrap case.
module tb_stage_i_bf2i;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, enable, s;
  logic signed [12:0] prvs_r, prvs_i;
  logic signed [13:0] tonext_r, tonext_i;
  logic primed;

  logic enable_b, s_b;
  logic signed [7:0] prvs_r_b, prvs_i_b;
  logic signed [7:0] tonext_r_b, tonext_i_b;
  logic primed_b;

  stage_i_bf2i #(.data_width(14), .add_g(1), .shift_stages(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .s(s),
    .prvs_r(prvs_r), .prvs_i(prvs_i),
    .tonext_r(tonext_r), .tonext_i(tonext_i), .primed(primed));

  stage_i_bf2i #(.data_width(8), .add_g(0), .shift_stages(1)) dut_b (
    .clock(clock), .reset(reset), .enable(enable_b), .s(s_b),
    .prvs_r(prvs_r_b), .prvs_i(prvs_i_b),
    .tonext_r(tonext_r_b), .tonext_i(tonext_i_b), .primed(primed_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input logic en, input logic sel, input int r, input int im);
    enable = en;
    s      = sel;
    prvs_r = 13'(r);
    prvs_i = 13'(im);
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic sel;
    int   r;
    int   im;
    int   exp_r;
    int   exp_i;
    logic exp_p;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Fill: d = 0 so outputs are 0; imag carries the 13-bit minimum.
    tbl[0]  = '{1'b0, 1,  -4096, 0,   0,     1'b0};
    tbl[1]  = '{1'b0, 2,  -4096, 0,   0,     1'b0};
    tbl[2]  = '{1'b0, 3,  -4096, 0,   0,     1'b0};
    tbl[3]  = '{1'b0, 4,  -4096, 0,   0,     1'b1};
    // Butterfly: sum d + x, difference d - x enters the line.
    tbl[4]  = '{1'b1, 10, -4096, 11,  -8192, 1'b1};
    tbl[5]  = '{1'b1, 20, -4096, 22,  -8192, 1'b1};
    tbl[6]  = '{1'b1, 30, -4096, 33,  -8192, 1'b1};
    tbl[7]  = '{1'b1, 40, -4096, 44,  -8192, 1'b1};
    // Drain the differences: 1-10, 2-20, ... and imag -4096-(-4096)=0.
    tbl[8]  = '{1'b0, 5,  7,     -9,  0,     1'b1};
    tbl[9]  = '{1'b0, 6,  7,     -18, 0,     1'b1};
    tbl[10] = '{1'b0, 7,  7,     -27, 0,     1'b1};
    tbl[11] = '{1'b0, 8,  7,     -36, 0,     1'b1};

    enable = 1'b0; s = 1'b0; prvs_r = '0; prvs_i = '0;
    enable_b = 1'b0; s_b = 1'b0; prvs_r_b = '0; prvs_i_b = '0;

    // Reset with random inputs and enable asserted.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b1, 1'(i), int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
    chk("rst_r", int'(tonext_r), 0);
    chk("rst_i", int'(tonext_i), 0);
    chk("rst_primed", int'(primed), 0);
    reset = 1'b0;

    // Hold: enable low, inputs ignored.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 100 + i, -50 - i);
    chk("hold_r", int'(tonext_r), 0);
    chk("hold_i", int'(tonext_i), 0);
    chk("hold_primed", int'(primed), 0);

    for (int k = 0; k < 12; k++) begin
      step(1'b1, tbl[k].sel, tbl[k].r, tbl[k].im);
      chk($sformatf("vec%0d_r", k), int'(tonext_r), tbl[k].exp_r);
      chk($sformatf("vec%0d_i", k), int'(tonext_i), tbl[k].exp_i);
      chk($sformatf("vec%0d_primed", k), int'(primed), int'(tbl[k].exp_p));
    end

    // Hold after activity keeps the last output.
    step(1'b0, 1'b1, 999, 999);
    chk("hold2_r", int'(tonext_r), -36);

    // Prime counter with enable gaps.
    reset = 1'b1; step(1'b1, 1'b0, 0, 0); reset = 1'b0;
    chk("prime_rst", int'(primed), 0);
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0); step(1'b0, 1'b0, 0, 0); step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    chk("prime_3rd", int'(primed), 0);
    step(1'b0, 1'b0, 0, 0);
    chk("prime_gap", int'(primed), 0);
    step(1'b1, 1'b0, 0, 0);
    chk("prime_4th", int'(primed), 1);

    // Mid-frame reset during the butterfly phase.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, i, 0);
    step(1'b1, 1'b1, 10, 0);
    chk("mid_pre_r", int'(tonext_r), 11);
    reset = 1'b1; step(1'b1, 1'b1, 20, 0); reset = 1'b0;
    chk("mid_rst_r", int'(tonext_r), 0);
    chk("mid_rst_primed", int'(primed), 0);
    step(1'b1, 1'b1, 7, -3);
    chk("mid_sum_r", int'(tonext_r), 7);
    chk("mid_sum_i", int'(tonext_i), -3);
    step(1'b1, 1'b1, 9, 0);
    step(1'b1, 1'b1, 9, 0);
    chk("mid_primed_3", int'(primed), 0);
    step(1'b1, 1'b1, 9, 0);
    chk("mid_primed_4", int'(primed), 1);
    // First difference (0-7, 0-(-3)) returns as d.
    step(1'b1, 1'b0, 0, 0);
    chk("mid_diff_r", int'(tonext_r), -7);
    chk("mid_diff_i", int'(tonext_i), 3);

    // Wrap with add_g=0, data_width=8, shift_stages=1 (instance b was reset above).
    chk("b_rst_primed", int'(primed_b), 0);
    enable_b = 1'b1; s_b = 1'b0; prvs_r_b = 8'sd100; prvs_i_b = -8'sd100;
    @(posedge clock); #1;
    chk("b_fill_r", int'(tonext_r_b), 0);
    chk("b_primed", int'(primed_b), 1);
    s_b = 1'b1;
    @(posedge clock); #1;
    chk("b_wrap_r", int'(tonext_r_b), -56);
    chk("b_wrap_i", int'(tonext_i_b), 56);
    s_b = 1'b0; prvs_r_b = '0; prvs_i_b = '0;
    @(posedge clock); #1;
    chk("b_diff_r", int'(tonext_r_b), 0);
    chk("b_diff_i", int'(tonext_i_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
